counter_step_sequencer: RTL and testbench
=========================================

# counter_step_sequencer

Sequencer that drives the team's 4-bit up/down counter through its enable and direction inputs. It accepts a move command (target value, mode, step rate) and issues single-cycle step strobes. In goto mode it runs until the counter reaches the target; in ping-pong mode it sweeps between 0 and the target until stopped. It sits between the pin-level command inputs and the counter datapath, replacing direct pin control of the counter's select line.

## Interface
- CNT_W, 4, counter and target width
- PRE_W, 4, prescale field width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled every cycle
- stop  in  1  abort; priority over start
- pause  in  1  level; freezes stepping while high
- mode  in  1  0 = goto, 1 = ping-pong
- target  in  CNT_W  endpoint, latched on start acceptance
- prescale  in  PRE_W  one step every prescale+1 cycles, latched on start acceptance
- cnt_q  in  CNT_W  counter value, sampled only on start acceptance
- cnt_en  out  1  one-cycle step strobe to the counter
- cnt_up  out  1  step direction, 1 = up; valid with cnt_en
- busy  out  1  high in UP/DOWN
- done  out  1  one-cycle completion pulse (goto mode only)

## Operation
- States: IDLE, UP, DOWN, DONE. Reset: IDLE, all outputs 0, pos=0, div=0.
- Start is accepted only in IDLE or DONE with stop=0. Acceptance latches target, prescale and mode, loads pos←cnt_q and clears div. Start is ignored while busy.
- Initial direction on acceptance:
  - goto: UP if pos<target; DOWN if pos>target; DONE if equal (no step).
  - ping-pong with target=0: DONE, no step.
  - ping-pong otherwise: UP if pos<target, else DOWN.
- Tick: in UP/DOWN with pause=0 and div==prescale_r. Each tick clears div; otherwise div increments. div holds while pause=1.
- On a tick: register cnt_en=1 and cnt_up=(state==UP), and set pos←pos±1. The next state is evaluated on the new pos:
  - goto: new pos==target → DONE.
  - ping-pong, moving UP: new pos==target → DOWN.
  - ping-pong, moving DOWN: new pos==0 → UP.
- DONE lasts one cycle with done=1, then returns to IDLE unless a new start is accepted.
- stop=1 in any state → IDLE at the next edge. No further cnt_en and no done.
- pos never wraps: moves are bounded to 0..2^CNT_W-1 by the endpoints. Counting is unsigned.
- cnt_up holds its last value between strobes.
- The counter is never stepped outside the sequencer once busy. The sequencer tracks its own shadow value pos and does not re-read cnt_q mid-run.

## Timing
- Start accepted in cycle 0 → state valid in cycle 1.
- First cnt_en appears in cycle prescale+2. Subsequent strobes are every prescale+1 cycles while pause is low.
- The final goto strobe and done are asserted in the same cycle.
- cnt_en and cnt_up are registered. The counter samples them at the end of that cycle.
- Pause raised in cycle k suppresses any tick in cycle k. Stepping resumes with div unchanged, so no step is lost or duplicated.
- Asynchronous reset mid-run drops cnt_en immediately. No done is issued.

## Structure
- Shared package holds:
  - state encoding: IDLE=0, UP=1, DOWN=2, DONE=3
  - MODE_GOTO=0, MODE_PINGPONG=1
  - default widths CNT_W=4, PRE_W=4
- Sub-module step_prescaler contains div, the tick compare, and clear/hold control. The FSM, pos register and output registers stay at top level.

## Test plan
- Reset during UP with cnt_en high → cnt_en, busy, done, cnt_up all 0 at once; IDLE after release.
- Goto up: cnt_q=3, target=5, prescale=0, start in cycle 0 → cnt_en in cycles 2 and 3 with cnt_up=1; done in cycle 3; busy in cycles 1–2.
- Goto equal: cnt_q=7, target=7 → no cnt_en; done in cycle 1. Goto down: cnt_q=9, target=6 → three strobes with cnt_up=0.
- Prescale: cnt_q=0, target=2, prescale=3 → cnt_en in cycles 5 and 9; done in cycle 9. Pause held for cycles 6–8 → second strobe moves to cycle 12.
- Ping-pong: cnt_q=0, target=2, prescale=0 → cnt_up sequence 1,1,0,0,1,1…. stop in the middle of the run → IDLE next cycle, no done. Start asserted while busy → ignored.

Source files
------------

// File: rtl/counter_step_sequencer_pkg.sv
// Shared definitions for the counter step sequencer: state encoding,
// move modes and default field widths.
package counter_step_sequencer_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_GOTO     = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

  // True while the sequencer is actively issuing steps.
  function automatic logic is_running(state_e s);
    return (s == ST_UP) || (s == ST_DOWN);
  endfunction

endpackage

// File: rtl/counter_step_sequencer_prescaler.sv
// Step-rate divider: produces one tick every prescale+1 running cycles.
// The divider freezes (holds) whenever run_i is low, so a pause never
// loses or duplicates a step.
module step_prescaler
  import counter_step_sequencer_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             run_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] div_q;
  logic [PRE_W-1:0] div_d;

  assign tick_o = run_i && (div_q == prescale_i);

  // Next divider value: clear on a new command or a tick, count while running, else hold.
  always_comb begin
    div_d = div_q;
    if (clr_i || tick_o) begin
      div_d = '0;
    end else if (run_i) begin
      div_d = div_q + PRE_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/counter_step_sequencer.sv
// Counter step sequencer: accepts a move command and drives the 4-bit
// up/down counter with single-cycle step strobes, either to a target
// (goto) or sweeping between 0 and the target (ping-pong).
module counter_step_sequencer
  import counter_step_sequencer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [CNT_W-1:0] target,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  state_e           start_state;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] target_q;
  logic [PRE_W-1:0] prescale_q;
  logic             mode_q;
  logic             cnt_en_q;
  logic             cnt_up_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             run;
  logic             tick;
  logic [CNT_W-1:0] pos_inc;
  logic [CNT_W-1:0] pos_dec;

  // A command is taken only when not already moving; stop always wins.
  assign accept  = start && !stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign run     = is_running(state_q) && !pause;
  assign pos_inc = pos_q + CNT_W'(1);
  assign pos_dec = pos_q - CNT_W'(1);

  // Pick the first state of a new command from the live counter value.
  always_comb begin
    start_state = ST_DONE;
    if (mode == MODE_GOTO) begin
      if (cnt_q < target) begin
        start_state = ST_UP;
      end else if (cnt_q > target) begin
        start_state = ST_DOWN;
      end
    end else if (target != '0) begin
      start_state = (cnt_q < target) ? ST_UP : ST_DOWN;
    end
  end

  step_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept),
    .run_i     (run),
    .prescale_i(prescale_q),
    .tick_o    (tick)
  );

  // Sequencer FSM with shadow position and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      target_q   <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_GOTO;
      cnt_en_q   <= 1'b0;
      cnt_up_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_en_q <= 1'b0;
      done_q   <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              target_q   <= target;
              prescale_q <= prescale;
              mode_q     <= mode;
              pos_q      <= cnt_q;
              state_q    <= start_state;
              busy_q     <= is_running(start_state);
              done_q     <= (start_state == ST_DONE);
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          ST_UP: begin
            if (tick) begin
              pos_q    <= pos_inc;
              cnt_en_q <= 1'b1;
              cnt_up_q <= 1'b1;
              if (pos_inc == target_q) begin
                if (mode_q == MODE_GOTO) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_DOWN;
                end
              end
            end
          end
          ST_DOWN: begin
            if (tick) begin
              pos_q    <= pos_dec;
              cnt_en_q <= 1'b1;
              cnt_up_q <= 1'b0;
              if ((mode_q == MODE_GOTO) && (pos_dec == target_q)) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if ((mode_q == MODE_PINGPONG) && (pos_dec == '0)) begin
                state_q <= ST_UP;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cnt_en = cnt_en_q;
  assign cnt_up = cnt_up_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Self-checking bench for counter_step_sequencer: directed scenarios with
// hand-derived cycle timelines plus randomized commands checked against a
// cycle-level behavioural model of the move rules.
module tb_counter_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause, mode;
  logic [3:0] target, prescale, cnt_q;
  logic       cnt_en, cnt_up, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle traces (cycle 0 = start cycle) and matching packed views.
  bit         en_tr[0:511], up_tr[0:511], busy_tr[0:511], done_tr[0:511];
  logic [63:0] en_v, up_v, busy_v, done_v;
  bit         exp_en[0:511], exp_up[0:511], exp_busy[0:511], exp_done[0:511];
  bit         pause_mask[0:511];
  int         junk_mask[0:511];
  bit         cmd2_mode;
  logic [3:0] cmd2_target, cmd2_pre, cmd2_cnt;
  bit         tb_last_up;

  always #5 clk = ~clk;

  counter_step_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .mode    (mode),
    .target  (target),
    .prescale(prescale),
    .cnt_q   (cnt_q),
    .cnt_en  (cnt_en),
    .cnt_up  (cnt_up),
    .busy    (busy),
    .done    (done)
  );

  // Issue one command in cycle 0, then run n cycles recording outputs.
  // Entered and left #1 after a rising edge.
  task automatic capture(input bit m, input logic [3:0] t, input logic [3:0] p,
                         input logic [3:0] c0, input int n, input int stop_c);
    start = 1'b1; mode = m; target = t; prescale = p; cnt_q = c0;
    stop = 1'b0; pause = 1'b0;
    en_v = '0; up_v = '0; busy_v = '0; done_v = '0;
    @(posedge clk); #1;
    start = 1'b0;
    target = 4'($urandom); cnt_q = 4'($urandom);
    for (int c = 1; c <= n; c++) begin
      pause = pause_mask[c];
      stop  = (c == stop_c);
      start = (junk_mask[c] != 0);
      if (junk_mask[c] == 1) begin
        mode = 1'($urandom); target = 4'($urandom);
        prescale = 4'($urandom); cnt_q = 4'($urandom);
      end else if (junk_mask[c] == 2) begin
        mode = cmd2_mode; target = cmd2_target; prescale = cmd2_pre; cnt_q = cmd2_cnt;
      end
      @(negedge clk);
      en_tr[c] = cnt_en; up_tr[c] = cnt_up; busy_tr[c] = busy; done_tr[c] = done;
      if (c < 64) begin
        en_v[c] = cnt_en; up_v[c] = cnt_up; busy_v[c] = busy; done_v[c] = done;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    for (int c = 0; c <= n + 1; c++) begin
      pause_mask[c] = 1'b0;
      junk_mask[c]  = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0; mode = 1'b0;
    target = 4'd9; prescale = 4'd0; cnt_q = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset cnt_en: got %b expected 0", cnt_en); end
    if (cnt_up !== 1'b0) begin n_fail++; $display("FAIL reset cnt_up: got %b expected 0", cnt_up); end
    if (busy   !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (done   !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks += 2;
    if (busy   !== 1'b0) begin n_fail++; $display("FAIL reset_release busy: got %b expected 0", busy); end
    if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_release cnt_en: got %b expected 0", cnt_en); end
    @(posedge clk); #1;
    tb_last_up = 1'b0;
    $display("txn reset: outputs cleared");
  endtask

  task automatic test_goto_up();
    capture(1'b0, 4'd5, 4'd0, 4'd3, 6, -1);
    n_checks += 4;
    if (en_v !== 64'h0C) begin n_fail++; $display("FAIL goto_up cnt_en cycles: got %h expected %h", en_v, 64'h0C); end
    if ((up_v & en_v) !== 64'h0C) begin n_fail++; $display("FAIL goto_up cnt_up on strobes: got %h expected %h", up_v & en_v, 64'h0C); end
    if (busy_v !== 64'h06) begin n_fail++; $display("FAIL goto_up busy cycles: got %h expected %h", busy_v, 64'h06); end
    if (done_v !== 64'h08) begin n_fail++; $display("FAIL goto_up done cycles: got %h expected %h", done_v, 64'h08); end
    $display("txn goto_up: cnt_q=3 target=5 prescale=0");
  endtask

  task automatic test_goto_equal_and_down();
    capture(1'b0, 4'd7, 4'd0, 4'd7, 4, -1);
    n_checks += 3;
    if (en_v !== 64'h0) begin n_fail++; $display("FAIL goto_equal cnt_en cycles: got %h expected 0", en_v); end
    if (busy_v !== 64'h0) begin n_fail++; $display("FAIL goto_equal busy cycles: got %h expected 0", busy_v); end
    if (done_v !== 64'h02) begin n_fail++; $display("FAIL goto_equal done cycles: got %h expected %h", done_v, 64'h02); end
    $display("txn goto_equal: cnt_q=7 target=7");
    capture(1'b0, 4'd6, 4'd0, 4'd9, 6, -1);
    n_checks += 4;
    if (en_v !== 64'h1C) begin n_fail++; $display("FAIL goto_down cnt_en cycles: got %h expected %h", en_v, 64'h1C); end
    if ((up_v & en_v) !== 64'h0) begin n_fail++; $display("FAIL goto_down cnt_up on strobes: got %h expected 0", up_v & en_v); end
    if (busy_v !== 64'h0E) begin n_fail++; $display("FAIL goto_down busy cycles: got %h expected %h", busy_v, 64'h0E); end
    if (done_v !== 64'h10) begin n_fail++; $display("FAIL goto_down done cycles: got %h expected %h", done_v, 64'h10); end
    $display("txn goto_down: cnt_q=9 target=6");
  endtask

  task automatic test_prescale_pause();
    capture(1'b0, 4'd2, 4'd3, 4'd0, 12, -1);
    n_checks += 4;
    if (en_v !== 64'h220) begin n_fail++; $display("FAIL prescale cnt_en cycles: got %h expected %h", en_v, 64'h220); end
    if ((up_v & en_v) !== 64'h220) begin n_fail++; $display("FAIL prescale cnt_up on strobes: got %h expected %h", up_v & en_v, 64'h220); end
    if (busy_v !== 64'h1FE) begin n_fail++; $display("FAIL prescale busy cycles: got %h expected %h", busy_v, 64'h1FE); end
    if (done_v !== 64'h200) begin n_fail++; $display("FAIL prescale done cycles: got %h expected %h", done_v, 64'h200); end
    $display("txn prescale: cnt_q=0 target=2 prescale=3");
    for (int c = 6; c <= 8; c++) pause_mask[c] = 1'b1;
    capture(1'b0, 4'd2, 4'd3, 4'd0, 15, -1);
    n_checks += 3;
    if (en_v !== 64'h1020) begin n_fail++; $display("FAIL pause cnt_en cycles: got %h expected %h", en_v, 64'h1020); end
    if (busy_v !== 64'hFFE) begin n_fail++; $display("FAIL pause busy cycles: got %h expected %h", busy_v, 64'hFFE); end
    if (done_v !== 64'h1000) begin n_fail++; $display("FAIL pause done cycles: got %h expected %h", done_v, 64'h1000); end
    $display("txn pause: prescale=3 with pause in cycles 6-8");
  endtask

  task automatic test_pingpong_stop();
    for (int c = 2; c <= 4; c++) junk_mask[c] = 1;
    capture(1'b1, 4'd2, 4'd0, 4'd0, 10, 6);
    n_checks += 4;
    if (en_v !== 64'h7C) begin n_fail++; $display("FAIL pingpong cnt_en cycles: got %h expected %h", en_v, 64'h7C); end
    if ((up_v & en_v) !== 64'h4C) begin n_fail++; $display("FAIL pingpong cnt_up on strobes: got %h expected %h", up_v & en_v, 64'h4C); end
    if (busy_v !== 64'h7E) begin n_fail++; $display("FAIL pingpong busy cycles: got %h expected %h", busy_v, 64'h7E); end
    if (done_v !== 64'h0) begin n_fail++; $display("FAIL pingpong done cycles: got %h expected 0", done_v); end
    $display("txn pingpong: target=2, starts while busy, stop in cycle 6");
  endtask

  task automatic test_back_to_back();
    cmd2_mode = 1'b0; cmd2_target = 4'd4; cmd2_pre = 4'd0; cmd2_cnt = 4'd5;
    junk_mask[3] = 2;
    capture(1'b0, 4'd5, 4'd0, 4'd3, 8, -1);
    n_checks += 4;
    if (en_v !== 64'h2C) begin n_fail++; $display("FAIL back_to_back cnt_en cycles: got %h expected %h", en_v, 64'h2C); end
    if ((up_v & en_v) !== 64'h0C) begin n_fail++; $display("FAIL back_to_back cnt_up on strobes: got %h expected %h", up_v & en_v, 64'h0C); end
    if (busy_v !== 64'h16) begin n_fail++; $display("FAIL back_to_back busy cycles: got %h expected %h", busy_v, 64'h16); end
    if (done_v !== 64'h28) begin n_fail++; $display("FAIL back_to_back done cycles: got %h expected %h", done_v, 64'h28); end
    $display("txn back_to_back: second goto accepted in DONE cycle");
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; mode = 1'b0; target = 4'd15; prescale = 4'd0; cnt_q = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks += 2;
    if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL midrun cnt_en before reset: got %b expected 1", cnt_en); end
    if (busy   !== 1'b1) begin n_fail++; $display("FAIL midrun busy before reset: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL midrun cnt_en in reset: got %b expected 0", cnt_en); end
    if (cnt_up !== 1'b0) begin n_fail++; $display("FAIL midrun cnt_up in reset: got %b expected 0", cnt_up); end
    if (busy   !== 1'b0) begin n_fail++; $display("FAIL midrun busy in reset: got %b expected 0", busy); end
    if (done   !== 1'b0) begin n_fail++; $display("FAIL midrun done in reset: got %b expected 0", done); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks += 3;
      if (busy   !== 1'b0) begin n_fail++; $display("FAIL midrun busy after release: got %b expected 0", busy); end
      if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL midrun cnt_en after release: got %b expected 0", cnt_en); end
      if (done   !== 1'b0) begin n_fail++; $display("FAIL midrun done after release: got %b expected 0", done); end
    end
    @(posedge clk); #1;
    tb_last_up = 1'b0;
    $display("txn reset_midrun: async reset during goto up");
  endtask

  // Random commands against a model built from the move rules: a step
  // happens after every prescale+1 un-paused busy cycles and lands one
  // cycle later; endpoints decide when to finish or turn around.
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      bit m, running, dir, cur_up;
      int t, p, c0, n, stop_c, pos, cnt;
      m  = 1'($urandom_range(0, 1));
      t  = $urandom_range(0, 15);
      p  = $urandom_range(0, 3);
      c0 = ($urandom_range(0, 7) == 0) ? t : $urandom_range(0, 15);
      n  = 10 + 32 * (p + 1);
      stop_c = (m || $urandom_range(0, 2) == 0) ? $urandom_range(2, n - 2) : n - 1;
      for (int c = 0; c <= n + 1; c++) begin
        exp_en[c] = 1'b0; exp_up[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
        pause_mask[c] = ($urandom_range(0, 3) == 0);
      end
      pos = c0; cnt = 0; cur_up = tb_last_up;
      if ((!m && c0 == t) || (m && t == 0)) begin
        running = 1'b0; dir = 1'b0; exp_done[1] = 1'b1;
      end else begin
        running = 1'b1;
        dir = m ? (c0 < t) : (t > c0);
      end
      for (int c = 1; c <= n; c++) begin
        exp_busy[c] = running;
        exp_up[c]   = cur_up;
        junk_mask[c] = (running && $urandom_range(0, 7) == 0) ? 1 : 0;
        if (c == stop_c) begin
          running = 1'b0;
        end else if (running && !pause_mask[c]) begin
          cnt++;
          if (cnt == p + 1) begin
            cnt = 0;
            pos = dir ? pos + 1 : pos - 1;
            cur_up = dir;
            exp_en[c + 1] = 1'b1;
            if (!m && pos == t) begin
              running = 1'b0; exp_done[c + 1] = 1'b1;
            end else if (m && dir && pos == t) begin
              dir = 1'b0;
            end else if (m && !dir && pos == 0) begin
              dir = 1'b1;
            end
          end
        end
      end
      $display("txn random %0d: mode=%0d cnt_q=%0d target=%0d prescale=%0d stop_cycle=%0d", it, m, c0, t, p, stop_c);
      capture(m, 4'(t), 4'(p), 4'(c0), n, stop_c);
      for (int c = 1; c <= n; c++) begin
        n_checks += 4;
        if (en_tr[c] !== exp_en[c]) begin n_fail++; $display("FAIL random%0d cnt_en cycle %0d: got %b expected %b", it, c, en_tr[c], exp_en[c]); end
        if (up_tr[c] !== exp_up[c]) begin n_fail++; $display("FAIL random%0d cnt_up cycle %0d: got %b expected %b", it, c, up_tr[c], exp_up[c]); end
        if (busy_tr[c] !== exp_busy[c]) begin n_fail++; $display("FAIL random%0d busy cycle %0d: got %b expected %b", it, c, busy_tr[c], exp_busy[c]); end
        if (done_tr[c] !== exp_done[c]) begin n_fail++; $display("FAIL random%0d done cycle %0d: got %b expected %b", it, c, done_tr[c], exp_done[c]); end
      end
      tb_last_up = cur_up;
    end
  endtask

  initial begin
    for (int c = 0; c < 512; c++) begin
      pause_mask[c] = 1'b0;
      junk_mask[c]  = 0;
    end
    test_reset();
    test_goto_up();
    test_goto_equal_and_down();
    test_prescale_pause();
    test_pingpong_stop();
    test_back_to_back();
    test_reset_midrun();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
